// File: rtl/flappy_game_ctrl.sv
// Per-frame flappy bird game controller: state machine, bird physics, pipe scroll, collisions, score.
// Latency: every output is registered and reflects the frame computed at the most recent clk edge.
// Backpressure: none; exactly one game frame advances per clk edge, and flap is sampled on each edge.
module flappy_game_ctrl #(
  parameter int H           = 24,
  parameter int W           = 64,
  parameter int BIRD_X      = 10,
  parameter int GAP         = 6,
  parameter int GRAVITY     = 1,
  parameter int FLAP_VEL    = -3,
  parameter int MAX_FALL    = 3,
  parameter int DEAD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flap,
  output logic [1:0]  state,
  output logic [7:0]  bird_y,
  output logic [7:0]  pipe_x,
  output logic [7:0]  gap_top,
  output logic [15:0] score,
  output logic        game_over,
  output logic [31:0] frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DEAD = 2'd2,
    S_BAD  = 2'd3
  } state_e;

  localparam int DCW = (DEAD_FRAMES > 1) ? $clog2(DEAD_FRAMES) : 1;

  localparam logic [7:0]        Y_MID     = 8'(H / 2);
  localparam logic [7:0]        Y_FLOOR   = 8'(H - 1);
  localparam logic signed [9:0] Y_FLOOR_S = 10'(H - 1);
  localparam logic [7:0]        PIPE_MAX  = 8'(W - 1);
  localparam logic [7:0]        GAP_MID   = 8'((H - GAP) / 2);
  localparam logic [7:0]        GAP_MOD   = 8'(H - GAP - 1);
  localparam logic [9:0]        GAP_W     = 10'(GAP);
  localparam logic [7:0]        BX_HIT    = 8'(BIRD_X);
  localparam logic [7:0]        BX_SCORE  = 8'(BIRD_X - 1);
  localparam logic signed [7:0] V_FLAP    = 8'(FLAP_VEL);
  localparam logic signed [7:0] V_GRAV    = 8'(GRAVITY);
  localparam logic signed [7:0] V_MAX     = 8'(MAX_FALL);
  localparam logic [7:0]        LFSR_SEED = 8'hA5;
  localparam logic [DCW-1:0]    DEAD_LAST = DCW'(DEAD_FRAMES - 1);

  // Registered game state
  state_e              state_q, state_d;
  logic [7:0]          bird_y_q, bird_y_d;
  logic signed [7:0]   vel_q, vel_d;
  logic [7:0]          pipe_x_q, pipe_x_d;
  logic [7:0]          gap_top_q, gap_top_d;
  logic [15:0]         score_q, score_d;
  logic                game_over_q, game_over_d;
  logic [31:0]         frame_cnt_q, frame_cnt_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic [DCW-1:0]      dead_cnt_q, dead_cnt_d;

  // Candidate values for a PLAY frame
  logic signed [9:0]   y_sum;
  logic                ceil_hit;
  logic                floor_hit;
  logic [7:0]          bird_play;
  logic signed [7:0]   vel_inc;
  logic signed [7:0]   vel_play;
  logic [7:0]          lfsr_step;
  logic [7:0]          pipe_play;
  logic [7:0]          gap_play;
  logic [7:0]          lfsr_play;
  logic                pipe_hit;
  logic                death;
  logic [15:0]         score_inc;

  // Bird physics: move with the old velocity, clamp at ceiling/floor, then update velocity
  always_comb begin
    y_sum     = $signed({2'b00, bird_y_q}) + $signed({{2{vel_q[7]}}, vel_q});
    ceil_hit  = y_sum[9];
    floor_hit = (y_sum >= Y_FLOOR_S);
    bird_play = y_sum[7:0];
    if (floor_hit) begin
      bird_play = Y_FLOOR;
    end else if (ceil_hit) begin
      bird_play = 8'd0;
    end
    vel_inc  = vel_q + V_GRAV;
    vel_play = (vel_inc > V_MAX) ? V_MAX : vel_inc;
    if (flap) begin
      vel_play = V_FLAP;
    end
  end

  // Pipe scroll with LFSR-chosen gap on wrap, plus collision and score qualification
  always_comb begin
    // Taps x^8+x^6+x^5+x^4+1 map to bits 7,5,4,3 of a left-shifting register
    lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    if (pipe_x_q == 8'd0) begin
      pipe_play = PIPE_MAX;
      lfsr_play = lfsr_step;
      gap_play  = 8'd1 + (lfsr_step % GAP_MOD);
    end else begin
      pipe_play = pipe_x_q - 8'd1;
      lfsr_play = lfsr_q;
      gap_play  = gap_top_q;
    end
    // Widen before adding GAP so a gap near the bottom cannot wrap the compare
    pipe_hit  = (pipe_play == BX_HIT) &&
                ((bird_play < gap_play) ||
                 ({2'b00, bird_play} >= ({2'b00, gap_play} + GAP_W)));
    death     = floor_hit || pipe_hit;
    score_inc = (score_q == 16'hFFFF) ? score_q : (score_q + 16'd1);
  end

  // Next-state and next-value selection for the game state machine
  always_comb begin
    state_d     = state_q;
    bird_y_d    = bird_y_q;
    vel_d       = vel_q;
    pipe_x_d    = pipe_x_q;
    gap_top_d   = gap_top_q;
    score_d     = score_q;
    game_over_d = 1'b0;
    frame_cnt_d = frame_cnt_q + 32'd1;
    lfsr_d      = lfsr_q;
    dead_cnt_d  = dead_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (flap) begin
          state_d  = S_PLAY;
          vel_d    = V_FLAP;
          score_d  = 16'd0;
          pipe_x_d = PIPE_MAX;
        end
      end

      S_PLAY: begin
        bird_y_d  = bird_play;
        pipe_x_d  = pipe_play;
        gap_top_d = gap_play;
        lfsr_d    = lfsr_play;
        if (death) begin
          // Floor and pipe hits in the same frame collapse into one death event
          state_d     = S_DEAD;
          game_over_d = 1'b1;
          dead_cnt_d  = '0;
          vel_d       = 8'sd0;
        end else begin
          vel_d = vel_play;
          if (pipe_play == BX_SCORE) begin
            score_d = score_inc;
          end
        end
      end

      S_DEAD: begin
        if (dead_cnt_q == DEAD_LAST) begin
          // Score stays visible in IDLE; the LFSR keeps its sequence across games
          state_d    = S_IDLE;
          bird_y_d   = Y_MID;
          vel_d      = 8'sd0;
          pipe_x_d   = PIPE_MAX;
          gap_top_d  = GAP_MID;
          dead_cnt_d = '0;
        end else begin
          dead_cnt_d = dead_cnt_q + 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean IDLE frame
        state_d    = S_IDLE;
        bird_y_d   = Y_MID;
        vel_d      = 8'sd0;
        pipe_x_d   = PIPE_MAX;
        gap_top_d  = GAP_MID;
        dead_cnt_d = '0;
      end
    endcase
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bird_y_q    <= Y_MID;
      vel_q       <= 8'sd0;
      pipe_x_q    <= PIPE_MAX;
      gap_top_q   <= GAP_MID;
      score_q     <= 16'd0;
      game_over_q <= 1'b0;
      frame_cnt_q <= 32'd0;
      lfsr_q      <= LFSR_SEED;
      dead_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bird_y_q    <= bird_y_d;
      vel_q       <= vel_d;
      pipe_x_q    <= pipe_x_d;
      gap_top_q   <= gap_top_d;
      score_q     <= score_d;
      game_over_q <= game_over_d;
      frame_cnt_q <= frame_cnt_d;
      lfsr_q      <= lfsr_d;
      dead_cnt_q  <= dead_cnt_d;
    end
  end

  assign state     = state_q;
  assign bird_y    = bird_y_q;
  assign pipe_x    = pipe_x_q;
  assign gap_top   = gap_top_q;
  assign score     = score_q;
  assign game_over = game_over_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl: default-gap instance A and wide-gap (GAP=18) instance B.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: none; stimulus is a fixed linear sequence of frames.
module tb_flappy_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, flap_a, flap_b;
  logic [1:0]  state_a, state_b;
  logic [7:0]  bird_y_a, bird_y_b, pipe_x_a, pipe_x_b, gap_top_a, gap_top_b;
  logic [15:0] score_a, score_b;
  logic        game_over_a, game_over_b;
  logic [31:0] frame_cnt_a, frame_cnt_b;

  int tests  = 0;
  int failed = 0;
  int edges_a = 0;
  int edges_b = 0;

  // Hand-computed bird rows
  int pat[7]     = '{12, 9, 7, 6, 6, 7, 9};       // flap every 7th frame, indexed by frame mod 7
  int fall[11]   = '{9, 7, 6, 6, 7, 9, 12, 15, 18, 21, 23};
  int ceil_y[10] = '{9, 6, 3, 0, 0, 0, 0, 0, 0, 0};

  flappy_game_ctrl dut_a (
    .clk(clk), .rst(rst_a), .flap(flap_a), .state(state_a), .bird_y(bird_y_a),
    .pipe_x(pipe_x_a), .gap_top(gap_top_a), .score(score_a), .game_over(game_over_a),
    .frame_cnt(frame_cnt_a)
  );

  flappy_game_ctrl #(.GAP(18)) dut_b (
    .clk(clk), .rst(rst_b), .flap(flap_b), .state(state_b), .bird_y(bird_y_b),
    .pipe_x(pipe_x_b), .gap_top(gap_top_b), .score(score_b), .game_over(game_over_b),
    .frame_cnt(frame_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_a) edges_a++;
    if (!rst_b) edges_b++;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; flap_a = 1'b0; flap_b = 1'b0;
    #12 rst_a = 1'b0;

    // Reset values
    chk("rst_state", state_a, 0);
    chk("rst_bird", bird_y_a, 12);
    chk("rst_pipe", pipe_x_a, 63);
    chk("rst_gap", gap_top_a, 9);
    chk("rst_score", score_a, 0);
    chk("rst_go", game_over_a, 0);
    chk("rst_fc", frame_cnt_a, 0);

    step();
    chk("idle_hold", state_a, 0);
    chk("idle_fc", frame_cnt_a, 1);

    // Free fall after a single flap
    flap_a = 1'b1;
    step();
    chk("t1_play", state_a, 1);
    chk("t1_start_bird", bird_y_a, 12);
    chk("t1_start_pipe", pipe_x_a, 63);
    flap_a = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      chk("t1_bird", bird_y_a, fall[i]);
      if (i < 10) begin
        chk("t1_alive", state_a, 1);
        chk("t1_go_low", game_over_a, 0);
      end
    end
    chk("t1_dead", state_a, 2);
    chk("t1_go_pulse", game_over_a, 1);
    chk("t1_pipe", pipe_x_a, 52);
    chk("t1_score", score_a, 0);

    // Dead timeout with flap held (ignored)
    flap_a = 1'b1;
    step();
    chk("t5_go_once", game_over_a, 0);
    chk("t5_dead1", state_a, 2);
    chk("t5_bird_hold", bird_y_a, 23);
    for (int i = 2; i < 60; i++) begin
      step();
      chk("t5_dead", state_a, 2);
    end
    chk("t5_pipe_hold", pipe_x_a, 52);
    step();
    chk("t5_idle", state_a, 0);
    chk("t5_bird", bird_y_a, 12);
    chk("t5_pipe", pipe_x_a, 63);
    chk("t5_gap", gap_top_a, 9);

    // Ceiling clamp with flap held
    step();
    chk("t2_play", state_a, 1);
    chk("t2_bird0", bird_y_a, 12);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t2_bird", bird_y_a, ceil_y[i]);
      chk("t2_alive", state_a, 1);
    end
    chk("t2_pipe", pipe_x_a, 53);
    chk("t2_fc", frame_cnt_a, edges_a);

    // Async reset between edges
    #2 rst_a = 1'b1;
    #1;
    chk("t6_state", state_a, 0);
    chk("t6_bird", bird_y_a, 12);
    chk("t6_pipe", pipe_x_a, 63);
    chk("t6_gap", gap_top_a, 9);
    chk("t6_score", score_a, 0);
    chk("t6_go", game_over_a, 0);
    chk("t6_fc", frame_cnt_a, 0);
    #1 rst_a = 1'b0;
    edges_a = 0;
    flap_a = 1'b0;
    step();
    chk("t6_idle", state_a, 0);
    chk("t6_fc1", frame_cnt_a, 1);

    // Pipe collision with 7-frame flap pattern
    flap_a = 1'b1;
    step();
    chk("t3_play", state_a, 1);
    for (int k = 1; k <= 53; k++) begin
      flap_a = ((k % 7) == 0);
      step();
      chk("t3_bird", bird_y_a, pat[k % 7]);
      if (k < 53) chk("t3_alive", state_a, 1);
    end
    chk("t3_pipe", pipe_x_a, 10);
    chk("t3_gap", gap_top_a, 9);
    chk("t3_dead", state_a, 2);
    chk("t3_go", game_over_a, 1);
    chk("t3_score", score_a, 0);
    flap_a = 1'b0;

    // Scoring on the wide-gap instance
    #2 rst_b = 1'b0;
    edges_b = 0;
    flap_b = 1'b1;
    step();
    chk("t4_play", state_b, 1);
    chk("t4_gap0", gap_top_b, 3);
    for (int k = 1; k <= 123; k++) begin
      flap_b = (k < 119) && ((k % 7) == 0);
      step();
      if (k <= 118) chk("t4_bird", bird_y_b, pat[k % 7]);
      else          chk("t4_fall", bird_y_b, fall[k - 113]);
      if (k < 123)  chk("t4_alive", state_b, 1);
      if (k == 53) chk("t4_score0", score_b, 0);
      if (k == 54) begin
        chk("t4_pipe9", pipe_x_b, 9);
        chk("t4_score1", score_b, 1);
      end
      if (k == 63) begin
        chk("t4_pipe0", pipe_x_b, 0);
        chk("t4_gap_hold", gap_top_b, 3);
      end
      if (k == 64) begin
        chk("t4_wrap", pipe_x_b, 63);
        chk("t4_gap_range", (gap_top_b >= 8'd1) && (gap_top_b <= 8'd5), 1);
      end
      if (k == 118) begin
        chk("t4_pipe9b", pipe_x_b, 9);
        chk("t4_score2", score_b, 2);
      end
    end
    chk("t4_dead", state_b, 2);
    chk("t4_go", game_over_b, 1);
    chk("t4_dead_pipe", pipe_x_b, 4);
    chk("t4_dead_score", score_b, 2);

    // Dead timeout keeps score for display, next flap clears it
    flap_b = 1'b1;
    for (int i = 1; i < 60; i++) begin
      step();
      chk("t5b_dead", state_b, 2);
      if (i == 1) chk("t5b_go_once", game_over_b, 0);
    end
    chk("t5b_bird_hold", bird_y_b, 23);
    chk("t5b_score_hold", score_b, 2);
    step();
    chk("t5b_idle", state_b, 0);
    chk("t5b_bird", bird_y_b, 12);
    chk("t5b_pipe", pipe_x_b, 63);
    chk("t5b_gap", gap_top_b, 3);
    chk("t5b_score_kept", score_b, 2);
    step();
    chk("t5b_replay", state_b, 1);
    chk("t5b_score_clr", score_b, 0);
    chk("t5b_fc", frame_cnt_b, edges_b);
    chk("t3_fc", frame_cnt_a, edges_a);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
